// File: rtl/adventure_pkg.sv
// Shared types and constants for the adventure game front end.
package adventure_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

  typedef enum logic [3:0] {
    NORTH = 4'b0001,
    SOUTH = 4'b0010,
    EAST  = 4'b0100,
    WEST  = 4'b1000
  } direction_t;

  // The counter width never drops to zero, even for a one-cycle debounce.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchronizer, stability counter, debounced level and
// rising-edge press event.
module button_debouncer
  import adventure_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pe
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  logic             sync1_r;
  logic             sync2_r;
  logic             deb_r;
  logic             deb_d_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronize, accept a level only after it has been stable long enough.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      deb_r   <= 1'b0;
      deb_d_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      if (sync2_r == deb_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_MAX) begin
        deb_r <= sync2_r;
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign pe = deb_r & ~deb_d_r;

endmodule

// File: rtl/direction_input.sv
// Turns four raw direction buttons into single-cycle move strobes, rejecting
// simultaneous presses and ignoring input once the game has ended.
module direction_input
  import adventure_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int MOVE_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_n,
  input  logic              btn_s,
  input  logic              btn_e,
  input  logic              btn_w,
  input  logic              game_over,
  output logic              n,
  output logic              s,
  output logic              e,
  output logic              w,
  output logic              conflict,
  output logic [MOVE_W-1:0] moves
);

  localparam logic [MOVE_W-1:0] MOVES_MAX = {MOVE_W{1'b1}};
  localparam logic [MOVE_W-1:0] MOVES_ONE = MOVE_W'(1'b1);

  logic [3:0]        raw_s;
  logic [3:0]        pe_s;
  logic [3:0]        dir_s;
  logic              conflict_s;
  logic              accept_s;
  logic [3:0]        dir_r;
  logic              conflict_r;
  logic [MOVE_W-1:0] moves_r;

  assign raw_s = {btn_w, btn_e, btn_s, btn_n};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk  (clk),
      .reset(reset),
      .btn  (raw_s[i]),
      .pe   (pe_s[i])
    );
  end

  // Arbitrate press events: a lone event is a move, several are a conflict.
  always_comb begin
    dir_s      = 4'b0000;
    conflict_s = 1'b0;
    accept_s   = 1'b0;
    if (game_over) begin
      dir_s      = 4'b0000;
      conflict_s = 1'b0;
      accept_s   = 1'b0;
    end else begin
      case (pe_s)
        4'b0000: begin
          dir_s = 4'b0000;
        end
        NORTH, SOUTH, EAST, WEST: begin
          dir_s    = pe_s;
          accept_s = 1'b1;
        end
        default: begin
          conflict_s = 1'b1;
        end
      endcase
    end
  end

  // Output strobes and the saturating move counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_r      <= 4'b0000;
      conflict_r <= 1'b0;
      moves_r    <= '0;
    end else begin
      dir_r      <= dir_s;
      conflict_r <= conflict_s;
      if (accept_s && (moves_r != MOVES_MAX)) begin
        moves_r <= moves_r + MOVES_ONE;
      end
    end
  end

  assign n        = dir_r[0];
  assign s        = dir_r[1];
  assign e        = dir_r[2];
  assign w        = dir_r[3];
  assign conflict = conflict_r;
  assign moves    = moves_r;

endmodule

// File: tb/tb_direction_input.sv
// Self-checking bench for direction_input: directed scenarios plus random
// button activity compared against a sample-history reference model.
module tb_direction_input;

  localparam int D  = 4;
  localparam int MW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          btn_n, btn_s, btn_e, btn_w, game_over;
  logic          n, s, e, w, conflict;
  logic [MW-1:0] moves;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  direction_input #(
    .DEBOUNCE_CYCLES(D),
    .MOVE_W         (MW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_n    (btn_n),
    .btn_s    (btn_s),
    .btn_e    (btn_e),
    .btn_w    (btn_w),
    .game_over(game_over),
    .n        (n),
    .s        (s),
    .e        (e),
    .w        (w),
    .conflict (conflict),
    .moves    (moves)
  );

  // Reference model: hist[b][k] is the raw level sampled k+1 edges ago; the
  // synchronized level seen at an edge is the raw level from two edges back.
  logic [D:0]    hist [4];
  logic [3:0]    m_deb, m_deb_d;
  logic [3:0]    exp_dir;
  logic          exp_conflict;
  logic [MW-1:0] exp_moves;

  function automatic logic all_differ(input logic [D:0] h, input logic d);
    for (int k = 1; k <= D; k++) begin
      if (h[k] == d) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [3:0] press_events(input logic [3:0] deb, input logic [3:0] deb_d);
    return deb & ~deb_d;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 4; b++) hist[b] <= '0;
      m_deb        <= 4'b0000;
      m_deb_d      <= 4'b0000;
      exp_dir      <= 4'b0000;
      exp_conflict <= 1'b0;
      exp_moves    <= '0;
    end else begin
      exp_dir <= (!game_over && $countones(press_events(m_deb, m_deb_d)) == 1)
                 ? press_events(m_deb, m_deb_d) : 4'b0000;
      exp_conflict <= !game_over && ($countones(press_events(m_deb, m_deb_d)) >= 2);
      if (!game_over && $countones(press_events(m_deb, m_deb_d)) == 1 && exp_moves != 2'b11)
        exp_moves <= exp_moves + 2'd1;
      m_deb_d <= m_deb;
      for (int b = 0; b < 4; b++) begin
        if (all_differ(hist[b], m_deb[b])) m_deb[b] <= ~m_deb[b];
      end
      hist[0] <= {hist[0][D-1:0], btn_n};
      hist[1] <= {hist[1][D-1:0], btn_s};
      hist[2] <= {hist[2][D-1:0], btn_e};
      hist[3] <= {hist[3][D-1:0], btn_w};
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    {btn_w, btn_e, btn_s, btn_n} = 4'b0000;
    game_over = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    {btn_w, btn_e, btn_s, btn_n} = 4'b1111;
    game_over = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({n, s, e, w, conflict, moves} !== 7'b0) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got=%b exp=0000000", i, {n, s, e, w, conflict, moves});
      end
    end
    {btn_w, btn_e, btn_s, btn_n} = 4'b0000;
    reset = 1'b0;
  endtask

  task automatic test_clean_press();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      btn_e = (i < 20);
      @(negedge clk);
      checks++;
      if ({n, s, e, w, conflict, moves} !== {exp_dir[0], exp_dir[1], exp_dir[2], exp_dir[3], exp_conflict, exp_moves}) begin
        failures++;
        $display("FAIL clean_press_model cyc=%0d got=%b exp=%b", i, {n, s, e, w, conflict, moves},
                 {exp_dir[0], exp_dir[1], exp_dir[2], exp_dir[3], exp_conflict, exp_moves});
      end
      checks++;
      if (e !== (i == 6)) begin
        failures++;
        $display("FAIL clean_press_e cyc=%0d got=%b exp=%b", i, e, (i == 6));
      end
    end
    checks++;
    if (moves !== 2'd1) begin
      failures++;
      $display("FAIL clean_press_moves got=%0d exp=1", moves);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] pat;
    pat = 4'b0101;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      btn_n = (i < 4) ? pat[i] : (i < 24);
      @(negedge clk);
      checks++;
      if ({n, s, e, w, conflict, moves} !== {exp_dir[0], exp_dir[1], exp_dir[2], exp_dir[3], exp_conflict, exp_moves}) begin
        failures++;
        $display("FAIL bounce_model cyc=%0d got=%b exp=%b", i, {n, s, e, w, conflict, moves},
                 {exp_dir[0], exp_dir[1], exp_dir[2], exp_dir[3], exp_conflict, exp_moves});
      end
      checks++;
      if (n !== (i == 10)) begin
        failures++;
        $display("FAIL bounce_n cyc=%0d got=%b exp=%b", i, n, (i == 10));
      end
    end
    checks++;
    if (moves !== 2'd1) begin
      failures++;
      $display("FAIL bounce_moves got=%0d exp=1", moves);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 28; i++) begin
      btn_n = (i < 16);
      btn_e = (i < 16);
      @(negedge clk);
      checks++;
      if ({n, e, conflict, moves} !== {1'b0, 1'b0, (i == 6), 2'd0}) begin
        failures++;
        $display("FAIL simultaneous cyc=%0d got n,e,conflict,moves=%b exp=%b", i,
                 {n, e, conflict, moves}, {1'b0, 1'b0, (i == 6), 2'd0});
      end
    end
  endtask

  task automatic test_game_over();
    do_reset();
    for (int i = 0; i < 48; i++) begin
      game_over = (i < 30);
      btn_s = ((i >= 2) && (i < 17)) || ((i >= 32) && (i < 45));
      @(negedge clk);
      checks++;
      if ({n, s, e, w, conflict, moves} !== {exp_dir[0], exp_dir[1], exp_dir[2], exp_dir[3], exp_conflict, exp_moves}) begin
        failures++;
        $display("FAIL game_over_model cyc=%0d got=%b exp=%b", i, {n, s, e, w, conflict, moves},
                 {exp_dir[0], exp_dir[1], exp_dir[2], exp_dir[3], exp_conflict, exp_moves});
      end
      checks++;
      if ({s, moves} !== {(i == 38), ((i >= 38) ? 2'd1 : 2'd0)}) begin
        failures++;
        $display("FAIL game_over_s cyc=%0d got s,moves=%b exp=%b", i, {s, moves},
                 {(i == 38), ((i >= 38) ? 2'd1 : 2'd0)});
      end
    end
    // game_over rising exactly in the cycle the press event appears
    do_reset();
    for (int i = 0; i < 16; i++) begin
      btn_s = 1'b1;
      game_over = (i >= 6);
      @(negedge clk);
      checks++;
      if ({s, conflict, moves} !== 4'b0000) begin
        failures++;
        $display("FAIL game_over_edge cyc=%0d got s,conflict,moves=%b exp=0000", i, {s, conflict, moves});
      end
    end
  endtask

  task automatic test_saturation();
    int sat_exp [5];
    sat_exp = '{1, 2, 3, 3, 3};
    do_reset();
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < 18; i++) begin
        btn_w = (i < 8);
        @(negedge clk);
        checks++;
        if ({n, s, e, w, conflict, moves} !== {exp_dir[0], exp_dir[1], exp_dir[2], exp_dir[3], exp_conflict, exp_moves}) begin
          failures++;
          $display("FAIL saturation_model press=%0d cyc=%0d got=%b exp=%b", p, i, {n, s, e, w, conflict, moves},
                   {exp_dir[0], exp_dir[1], exp_dir[2], exp_dir[3], exp_conflict, exp_moves});
        end
      end
      checks++;
      if (moves !== sat_exp[p][MW-1:0]) begin
        failures++;
        $display("FAIL saturation_moves press=%0d got=%0d exp=%0d", p, moves, sat_exp[p]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    btn_w = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({n, s, e, w, conflict, moves} !== 7'b0) begin
      failures++;
      $display("FAIL reset_mid_async got=%b exp=0000000", {n, s, e, w, conflict, moves});
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      checks++;
      if ({w, conflict, moves} !== {(j == 6), 1'b0, ((j >= 6) ? 2'd1 : 2'd0)}) begin
        failures++;
        $display("FAIL reset_mid_w cyc=%0d got w,conflict,moves=%b exp=%b", j, {w, conflict, moves},
                 {(j == 6), 1'b0, ((j >= 6) ? 2'd1 : 2'd0)});
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] lvl;
    int         hold [4];
    int         b1, b2;
    lvl = 4'b0000;
    for (int b = 0; b < 4; b++) hold[b] = $urandom_range(1, 20);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (hold[b] == 0) begin
          lvl[b]  = ~lvl[b];
          hold[b] = lvl[b] ? $urandom_range(1, 14) : $urandom_range(1, 24);
        end else begin
          hold[b] = hold[b] - 1;
        end
      end
      if ($urandom_range(0, 49) == 0) begin
        b1 = $urandom_range(0, 3);
        b2 = (b1 + 1 + $urandom_range(0, 2)) % 4;
        lvl[b1] = 1'b1;
        lvl[b2] = 1'b1;
        hold[b1] = 12;
        hold[b2] = 12;
      end
      if ($urandom_range(0, 79) == 0) game_over = ~game_over;
      {btn_w, btn_e, btn_s, btn_n} = lvl;
      @(negedge clk);
      checks++;
      if ({n, s, e, w, conflict, moves} !== {exp_dir[0], exp_dir[1], exp_dir[2], exp_dir[3], exp_conflict, exp_moves}) begin
        failures++;
        $display("FAIL random_model cyc=%0d got=%b exp=%b", i, {n, s, e, w, conflict, moves},
                 {exp_dir[0], exp_dir[1], exp_dir[2], exp_dir[3], exp_conflict, exp_moves});
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    {btn_w, btn_e, btn_s, btn_n} = 4'b0000;
    game_over = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_game_over();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
